// File: rtl/zero_shift_pkg.sv
// Shared types and sizing helpers for the Zero machine iterative shift unit.
package zero_shift_pkg;

  typedef enum logic [1:0] {
    SHL = 2'd0,
    SHR = 2'd1,
    SAR = 2'd2,
    ROR = 2'd3
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_t;

  localparam int ZS_WIDTH = 12;
  localparam int ZS_AMT_W = $clog2(ZS_WIDTH + 1);

  // Bits needed to hold a count in 0..width inclusive.
  function automatic int amt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/zero_shift_step.sv
// One combinational shift step of s bits (s <= STEP); carry is the last bit moved out.
module zero_shift_step
  import zero_shift_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int STEP  = 1,
  localparam int SW   = amt_w(STEP)
) (
  input  logic [WIDTH-1:0] value_i,
  input  shift_op_t        op_i,
  input  logic [SW-1:0]    s_i,
  input  logic             sign_i,
  output logic [WIDTH-1:0] next_o,
  output logic             carry_o
);

  // Each op shifts through one spare bit so the carry falls out of the same shift.
  always_comb begin
    next_o  = value_i;
    carry_o = 1'b0;
    case (op_i)
      SHL: {carry_o, next_o} = {1'b0, value_i} << s_i;
      SHR: {next_o, carry_o} = {value_i, 1'b0} >> s_i;
      SAR: {next_o, carry_o} = (WIDTH+1)'($signed({sign_i, value_i, 1'b0}) >>> s_i);
      ROR: begin
        next_o  = WIDTH'({value_i, value_i} >> s_i);
        carry_o = next_o[WIDTH-1];
      end
      default: ;
    endcase
    if (s_i == '0) carry_o = 1'b0;
  end

endmodule

// File: rtl/zero_shift_unit.sv
// Handshaked iterative shifter: accepts an op in IDLE, shifts STEP bits/cycle, holds result in DONE.
module zero_shift_unit
  import zero_shift_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int STEP  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_value,
  input  logic [WIDTH-1:0] in_amount,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  localparam int CW = amt_w(WIDTH);
  localparam int SW = amt_w(STEP);

  shift_state_t     state_q;
  shift_op_t        op_q;
  logic [WIDTH-1:0] val_q;
  logic [CW-1:0]    rem_q;
  logic             carry_q;
  logic             sign_q;
  logic             vld_q;
  logic [CNT_W-1:0] ops_q;

  logic [CW-1:0]    n_d;
  logic [SW-1:0]    s_d;
  logic [WIDTH-1:0] step_val;
  logic             step_carry;

  // Rotates wrap the amount; shifts saturate it at WIDTH.
  always_comb begin
    if (shift_op_t'(in_op) == ROR) n_d = CW'(int'(in_amount) % WIDTH);
    else if (int'(in_amount) >= WIDTH) n_d = CW'(WIDTH);
    else n_d = CW'(in_amount);
    s_d = (int'(rem_q) < STEP) ? SW'(rem_q) : SW'(STEP);
  end

  zero_shift_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .value_i (val_q),
    .op_i    (op_q),
    .s_i     (s_d),
    .sign_i  (sign_q),
    .next_o  (step_val),
    .carry_o (step_carry)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= SHL;
      val_q   <= '0;
      rem_q   <= '0;
      carry_q <= 1'b0;
      sign_q  <= 1'b0;
      vld_q   <= 1'b0;
      ops_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          op_q    <= shift_op_t'(in_op);
          val_q   <= in_value;
          sign_q  <= in_value[WIDTH-1];
          carry_q <= 1'b0;
          rem_q   <= n_d;
          state_q <= (n_d == '0) ? DONE : SHIFT;
        end
        SHIFT: begin
          val_q   <= step_val;
          carry_q <= step_carry;
          rem_q   <= rem_q - CW'(s_d);
          if (rem_q == CW'(s_d)) state_q <= DONE;
        end
        // out_valid is raised one cycle after entering DONE, giving latency 1+ceil(n/STEP).
        DONE: begin
          if (!vld_q) vld_q <= 1'b1;
          else if (out_ready) begin
            vld_q   <= 1'b0;
            state_q <= IDLE;
            ops_q   <= ops_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign out_valid  = vld_q;
  assign out_result = val_q;
  assign out_carry  = carry_q;
  assign ops_done   = ops_q;

endmodule

// File: tb/tb_zero_shift_unit.sv
// Drives a STEP=1 and a STEP=4 unit with the same requests and checks both against a bit-level model.
module tb_zero_shift_unit;

  localparam int W = 12;
  localparam int M = 4095;

  logic        clock, reset, in_valid, out_ready;
  logic [1:0]  in_op;
  logic [11:0] in_value, in_amount;
  logic        in_ready1, out_valid1, out_carry1, busy1;
  logic [11:0] out_result1;
  logic [15:0] ops_done1;
  logic        in_ready4, out_valid4, out_carry4, busy4;
  logic [11:0] out_result4;
  logic [15:0] ops_done4;

  int n_pass = 0;
  int n_total = 0;
  int exp_done = 0;

  zero_shift_unit #(.WIDTH(12), .STEP(1), .CNT_W(16)) u1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_op(in_op), .in_value(in_value), .in_amount(in_amount),
    .out_valid(out_valid1), .out_ready(out_ready), .out_result(out_result1),
    .out_carry(out_carry1), .busy(busy1), .ops_done(ops_done1));

  zero_shift_unit #(.WIDTH(12), .STEP(4), .CNT_W(16)) u4 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .in_op(in_op), .in_value(in_value), .in_amount(in_amount),
    .out_valid(out_valid4), .out_ready(out_ready), .out_result(out_result4),
    .out_carry(out_carry4), .busy(busy4), .ops_done(ops_done4));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: the shift by n computed in one go with integer arithmetic.
  function automatic void ref_op(input int op, input int v, input int amt,
                                 output int res, output int cy, output int n);
    int sv;
    if (op == 3) n = amt % W;
    else n = (amt > W) ? W : amt;
    res = v;
    cy  = 0;
    if (n > 0) begin
      case (op)
        0: begin res = (v << n) & M; cy = (v >> (W - n)) & 1; end
        1: begin res = v >> n;       cy = (v >> (n - 1)) & 1; end
        2: begin
          sv  = (((v >> 11) & 1) == 1) ? v - 4096 : v;
          res = (sv >>> n) & M;
          cy  = (v >> (n - 1)) & 1;
        end
        default: begin
          res = ((v >> n) | (v << (W - n))) & M;
          cy  = (res >> (W - 1)) & 1;
        end
      endcase
    end
  endfunction

  task automatic wait_idle();
    int e = 0;
    while (!(in_ready1 && in_ready4) && e < 100) begin
      @(negedge clock);
      e++;
    end
    check("idle_wait", 32'(e < 100), 1);
  endtask

  task automatic run_op(input int op, input int v, input int amt, input int hold);
    int r, c, n, l1, l4;
    ref_op(op, v, amt, r, c, n);
    wait_idle();
    in_op = op[1:0]; in_value = v[11:0]; in_amount = amt[11:0]; in_valid = 1'b1;
    @(negedge clock);
    // Scramble the request inputs: only the accept-edge values may matter.
    in_valid = 1'b0; in_op = 2'($urandom); in_value = 12'($urandom); in_amount = 12'($urandom);
    l1 = 0; l4 = 0;
    for (int i = 1; i <= 40 && (l1 == 0 || l4 == 0); i++) begin
      @(negedge clock);
      if (out_valid1 && l1 == 0) l1 = i;
      if (out_valid4 && l4 == 0) l4 = i;
    end
    check("lat_s1", l1, 1 + n);
    check("lat_s4", l4, 1 + (n + 3) / 4);
    check("res_s1", out_result1, r);
    check("cy_s1", out_carry1, c);
    check("res_s4", out_result4, r);
    check("cy_s4", out_carry4, c);
    if (hold > 0) begin
      in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clock);
        check("bp_valid", {out_valid1, out_valid4}, 2'b11);
        check("bp_ready", {in_ready1, in_ready4, busy1, busy4}, 4'b0011);
        check("bp_res", {out_result1, out_result4}, {r[11:0], r[11:0]});
        check("bp_cy", {out_carry1, out_carry4}, {c[0], c[0]});
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    exp_done++;
    check("done_s1", ops_done1, exp_done & 16'hFFFF);
    check("done_s4", ops_done4, exp_done & 16'hFFFF);
    check("consumed", {out_valid1, out_valid4, in_ready1, in_ready4}, 4'b0011);
  endtask

  initial begin
    int stale;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_value = '0; in_amount = '0;
    repeat (2) @(negedge clock);
    check("rst_s1", {in_ready1, out_valid1, out_result1, out_carry1, busy1, ops_done1},
          {1'b1, 1'b0, 12'h0, 1'b0, 1'b0, 16'h0});
    check("rst_s4", {in_ready4, out_valid4, out_result4, out_carry4, busy4, ops_done4},
          {1'b1, 1'b0, 12'h0, 1'b0, 1'b0, 16'h0});
    reset = 1'b0;
    @(negedge clock);

    // Reset four cycles into a long left shift: the operation must vanish.
    in_op = 2'd0; in_value = 12'h5A3; in_amount = 12'd10; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("mid_busy", {busy1, out_valid1}, 2'b10);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mrst_s1", {in_ready1, out_valid1, out_result1, ops_done1}, {1'b1, 1'b0, 12'h0, 16'h0});
    check("mrst_s4", {in_ready4, out_valid4, out_result4, ops_done4}, {1'b1, 1'b0, 12'h0, 16'h0});
    stale = 0;
    repeat (20) begin
      @(negedge clock);
      if (out_valid1 || out_valid4) stale++;
    end
    check("no_stale", stale, 0);

    run_op(1, 12'h004, 1, 0);
    run_op(0, 12'h801, 1, 0);
    run_op(2, 12'h800, 3, 0);
    run_op(1, 12'hFFF, 20, 0);
    run_op(2, 12'h9AB, 40, 0);
    run_op(3, 12'h001, 13, 0);
    run_op(3, 12'h001, 12, 0);
    run_op(0, 12'hA5B, 12, 0);
    run_op(1, 12'h6C3, 7, 5);

    for (int k = 0; k < 30; k++)
      run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)),
             int'($urandom_range(0, 40)), int'($urandom_range(0, 2)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
